arbiter8_rr: RTL and testbench

- Grants a single shared resource to one of 8 requesters, one owner at a time.
- Requests are active-low, matching the team's 8-3 priority encoder input convention.
- Two modes: fixed priority (index 7 highest, same ordering as the encoder) and round-robin (fair rotation).
- Sits in front of any shared datapath unit (bus, display driver, ALU). Owner is reported one-hot and as a binary id.

---
 rtl/arbiter8_rr_pkg.sv | 18 +
 rtl/arbiter8_rr_pri_sel8.sv | 25 ++
 rtl/arbiter8_rr.sv | 118 +++++++++++
 tb/tb_arbiter8_rr.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/arbiter8_rr_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Holds FSM state encoding, mode encoding and a one-hot helper.
package arbiter8_rr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/arbiter8_rr_pri_sel8.sv
// Combinational downward-wrapping priority selector over 8 active-low requests.
// Ports: req_n (active-low requests), start (first index searched), win, found.
module pri_sel8 (
    input  logic [7:0] req_n,
    input  logic [2:0] start,
    output logic [2:0] win,
    output logic       found
);

    always_comb begin : search
        logic [2:0] idx;
        win   = start;
        found = 1'b0;
        idx   = start;
        // Search start, start-1, ... wrapping 0 -> 7; first hit wins.
        for (int k = 0; k < 8; k++) begin
            idx = start - 3'(k);
            if (!found && !req_n[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbiter8_rr.sv
// Shared-resource arbiter for 8 active-low requesters, fixed or round-robin.
// Ports: iClk, iRst_n, iEI (active-low enable), iMode, iReq -> oGrant, oGrantId, oBusy, oTimeout.
module arbiter8_rr
    import arbiter8_rr_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iEI,
    input  logic       iMode,
    input  logic [7:0] iReq,
    output logic [7:0] oGrant,
    output logic [2:0] oGrantId,
    output logic       oBusy,
    output logic       oTimeout
);

    localparam int CNT_W = $clog2(MAX_HOLD);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       ptr, ptr_n;
    logic [7:0]       grant, grant_n;
    logic [2:0]       id, id_n;
    logic             busy, busy_n;
    logic             tmo, tmo_n;

    logic [2:0] start;
    logic [2:0] win;
    logic       found;

    // Fixed mode always starts at 7; RR starts just below the last owner.
    assign start = (iMode == MODE_RR) ? ptr - 3'd1 : 3'd7;

    pri_sel8 u_sel (
        .req_n (iReq),
        .start (start),
        .win   (win),
        .found (found)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ptr   <= 3'd0;
            grant <= 8'h00;
            id    <= 3'd0;
            busy  <= 1'b0;
            tmo   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
            grant <= grant_n;
            id    <= id_n;
            busy  <= busy_n;
            tmo   <= tmo_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        grant_n = grant;
        id_n    = id;
        busy_n  = busy;
        tmo_n   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!iEI && found) begin
                    state_n = ST_GRANT;
                    cnt_n   = '0;
                    grant_n = onehot8(win);
                    id_n    = win;
                    busy_n  = 1'b1;
                end
            end
            ST_GRANT: begin
                // Disable beats release, release beats timeout.
                if (iEI) begin
                    state_n = ST_IDLE;
                    grant_n = 8'h00;
                    busy_n  = 1'b0;
                end else if (iReq[id]) begin
                    state_n = ST_GAP;
                    grant_n = 8'h00;
                    busy_n  = 1'b0;
                    ptr_n   = id;
                end else if (cnt == CNT_W'(MAX_HOLD - 1)) begin
                    state_n = ST_GAP;
                    grant_n = 8'h00;
                    busy_n  = 1'b0;
                    ptr_n   = id;
                    tmo_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = 8'h00;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign oGrant   = grant;
    assign oGrantId = id;
    assign oBusy    = busy;
    assign oTimeout = tmo;

endmodule

// File: tb/tb_arbiter8_rr.sv
// Directed bench for arbiter8_rr built with MAX_HOLD = 4.
// Covers reset, fixed, round-robin, timeout, disable and async reset.
module tb_arbiter8_rr;

    logic       iClk = 1'b0;
    logic       iRst_n;
    logic       iEI;
    logic       iMode;
    logic [7:0] iReq;
    logic [7:0] oGrant;
    logic [2:0] oGrantId;
    logic       oBusy;
    logic       oTimeout;

    int compared = 0;
    int mismatched = 0;

    arbiter8_rr #(.MAX_HOLD(4)) dut (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iEI      (iEI),
        .iMode    (iMode),
        .iReq     (iReq),
        .oGrant   (oGrant),
        .oGrantId (oGrantId),
        .oBusy    (oBusy),
        .oTimeout (oTimeout)
    );

    always #5 iClk = ~iClk;

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, oGrant, 8'h00);
        chk({tag, "_busy"}, {7'd0, oBusy}, 8'h00);
    endtask

    task automatic chk_own(input string tag, input logic [2:0] exp_id);
        logic [7:0] oh;
        oh = 8'h01 << exp_id;
        chk({tag, "_grant"}, oGrant, oh);
        chk({tag, "_id"}, {5'd0, oGrantId}, {5'd0, exp_id});
        chk({tag, "_busy"}, {7'd0, oBusy}, 8'h01);
    endtask

    initial begin
        logic [2:0] exp_id;
        iRst_n = 1'b0;
        iEI    = 1'b0;
        iMode  = 1'b0;
        iReq   = 8'h00;
        #2;
        chk_idle("rst");
        chk("rst_id", {5'd0, oGrantId}, 8'h00);
        chk("rst_tmo", {7'd0, oTimeout}, 8'h00);
        #10;
        iRst_n = 1'b1;

        step();
        chk_own("first", 3'd7);

        iReq = 8'b01011111;
        step();
        step();
        chk_own("fix_hold3", 3'd7);
        iReq = 8'b11011111;
        step();
        chk_idle("fix_gap");
        chk("fix_gap_tmo", {7'd0, oTimeout}, 8'h00);
        step();
        chk_idle("fix_idle");
        step();
        chk_own("fix_next", 3'd5);

        iReq = 8'hFF;
        step();
        step();
        #3;
        iRst_n = 1'b0;
        #1;
        chk_idle("rst2");
        #2;
        iRst_n = 1'b1;
        iMode  = 1'b1;
        iReq   = 8'h00;

        step();
        for (int i = 0; i < 9; i++) begin
            exp_id = 3'(7 - i);
            chk_own($sformatf("rr%0d", i), exp_id);
            if (i < 8) begin
                iReq = 8'h01 << exp_id;
                step();
                chk_idle($sformatf("rr%0d_gap", i));
                iReq = 8'h00;
                step();
                chk_idle($sformatf("rr%0d_idle", i));
                step();
            end
        end

        iReq = 8'hFF;
        step();
        chk_idle("to_gap0");
        iReq = 8'b11110111;
        step();
        chk_idle("to_idle0");
        step();
        chk_own("to_c1", 3'd3);
        step();
        iReq = 8'b11110101;
        step();
        step();
        chk_own("to_c4", 3'd3);
        chk("to_c4_tmo", {7'd0, oTimeout}, 8'h00);
        step();
        chk_idle("to_drop");
        chk("to_pulse", {7'd0, oTimeout}, 8'h01);
        step();
        chk("to_pulse_end", {7'd0, oTimeout}, 8'h00);
        chk_idle("to_idle1");
        step();
        chk_own("to_next", 3'd1);

        step();
        chk_own("dis_c2", 3'd1);
        iEI = 1'b1;
        step();
        chk_idle("dis_drop");
        chk("dis_tmo", {7'd0, oTimeout}, 8'h00);
        iReq = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle($sformatf("dis_hold%0d", i));
        end
        iEI = 1'b0;
        step();
        chk_own("dis_ptr", 3'd2);

        #3;
        iRst_n = 1'b0;
        #1;
        chk_idle("arst");
        chk("arst_id", {5'd0, oGrantId}, 8'h00);
        chk("arst_tmo", {7'd0, oTimeout}, 8'h00);
        #2;
        iRst_n = 1'b1;
        step();
        chk_own("arst_first", 3'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
